nios2_freertos_led_out: RTL and testbench



---
 rtl/nios2_freertos_led_out.sv | 126 ++++++++++++
 tb/tb_nios2_freertos_led_out.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_freertos_led_out.sv
// Avalon-MM LED output port: DATA register with atomic set/clear, plus a
// per-bit hardware blink engine driven by a clock prescaler.
module nios2_freertos_led_out #(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0,
  parameter int unsigned           PRESCALE    = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam int unsigned PRESC_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned PERIOD_W = 16;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  logic [WIDTH-1:0]    r_data;
  logic [WIDTH-1:0]    r_blink_en;
  logic [PERIOD_W-1:0] r_period;
  logic [PRESC_W-1:0]  r_presc;
  logic [PERIOD_W-1:0] r_half_cnt;
  logic                r_phase;
  logic [31:0]         r_readdata;
  logic [WIDTH-1:0]    r_out_port;

  logic                w_wr;
  logic                w_wr_period;
  logic                w_tick;
  logic                w_half_done;
  logic [WIDTH-1:0]    w_wdata;
  logic [WIDTH-1:0]    w_data_next;
  logic [31:0]         w_rd_mux;
  logic                w_unused;

  assign w_wr        = chipselect & ~write_n;
  assign w_wr_period = w_wr & (address == ADDR_PERIOD);
  assign w_wdata     = writedata[WIDTH-1:0];
  assign w_tick      = (r_presc == PRESC_W'(PRESCALE - 1));
  assign w_half_done = (r_half_cnt == (r_period - PERIOD_W'(1)));
  assign w_unused    = ^writedata;

  // Next DATA value: direct write or atomic set/clear
  always_comb begin
    w_data_next = r_data;
    if (w_wr) begin
      case (address)
        ADDR_DATA:     w_data_next = w_wdata;
        ADDR_OUTSET:   w_data_next = r_data | w_wdata;
        ADDR_OUTCLEAR: w_data_next = r_data & ~w_wdata;
        default:       w_data_next = r_data;
      endcase
    end
  end

  // Read mux; unused bits and write-only registers read as zero
  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA:     w_rd_mux = 32'(r_data);
      ADDR_BLINK_EN: w_rd_mux = 32'(r_blink_en);
      ADDR_PERIOD:   w_rd_mux = 32'(r_period);
      ADDR_STATUS:   w_rd_mux = 32'(r_phase);
      default:       w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data     <= RESET_VALUE;
      r_blink_en <= '0;
      r_period   <= '0;
    end else begin
      r_data <= w_data_next;
      if (w_wr && (address == ADDR_BLINK_EN)) r_blink_en <= w_wdata;
      if (w_wr_period)                        r_period   <= writedata[PERIOD_W-1:0];
    end
  end

  // Blink engine; a PERIOD write restarts it even if the value is unchanged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc    <= '0;
      r_half_cnt <= '0;
      r_phase    <= 1'b0;
    end else if (w_wr_period || (r_period == '0)) begin
      r_presc    <= '0;
      r_half_cnt <= '0;
      r_phase    <= 1'b0;
    end else if (w_tick) begin
      r_presc <= '0;
      if (w_half_done) begin
        r_half_cnt <= '0;
        r_phase    <= ~r_phase;
      end else begin
        r_half_cnt <= r_half_cnt + PERIOD_W'(1);
      end
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_readdata <= '0;
      r_out_port <= RESET_VALUE;
    end else begin
      r_readdata <= w_rd_mux;
      r_out_port <= r_data ^ (r_blink_en & {WIDTH{r_phase}});
    end
  end

  assign readdata = r_readdata;
  assign out_port = r_out_port;

endmodule

// File: tb/tb_nios2_freertos_led_out.sv
// Directed self-checking bench for nios2_freertos_led_out (WIDTH=8, PRESCALE=4).
`timescale 1ns/1ps
module tb_nios2_freertos_led_out;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int n_cmp;
  int n_mis;

  nios2_freertos_led_out #(
    .WIDTH      (8),
    .RESET_VALUE(8'h00),
    .PRESCALE   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] v);
    address = a;
    @(posedge clk);
    #1;
    v = readdata;
  endtask

  task automatic test_reset;
    tick(3);
    n_cmp++;
    if (out_port !== 8'h00) begin
      n_mis++; $display("FAIL reset_out_port: got %h expected %h", out_port, 8'h00);
    end
    n_cmp++;
    if (readdata !== 32'h0) begin
      n_mis++; $display("FAIL reset_readdata: got %h expected %h", readdata, 32'h0);
    end
    reset = 1'b0;
  endtask

  task automatic test_data_write;
    logic [31:0] v;
    bus_write(3'd0, 32'h0000_01A5);
    n_cmp++;
    if (out_port !== 8'h00) begin
      n_mis++; $display("FAIL data_out_latency: got %h expected %h", out_port, 8'h00);
    end
    bus_read(3'd0, v);
    n_cmp++;
    if (v !== 32'h0000_00A5) begin
      n_mis++; $display("FAIL data_readback: got %h expected %h", v, 32'h0000_00A5);
    end
    n_cmp++;
    if (out_port !== 8'hA5) begin
      n_mis++; $display("FAIL data_out_port: got %h expected %h", out_port, 8'hA5);
    end
  endtask

  task automatic test_set_clear;
    logic [31:0] v;
    bus_write(3'd0, 32'h0000_00F0);
    bus_write(3'd4, 32'h0000_000F);
    bus_read(3'd0, v);
    n_cmp++;
    if (v !== 32'h0000_00FF) begin
      n_mis++; $display("FAIL outset: got %h expected %h", v, 32'h0000_00FF);
    end
    bus_write(3'd5, 32'h0000_0081);
    bus_read(3'd0, v);
    n_cmp++;
    if (v !== 32'h0000_007E) begin
      n_mis++; $display("FAIL outclear: got %h expected %h", v, 32'h0000_007E);
    end
    n_cmp++;
    if (out_port !== 8'h7E) begin
      n_mis++; $display("FAIL outclear_out_port: got %h expected %h", out_port, 8'h7E);
    end
    bus_read(3'd4, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_mis++; $display("FAIL read_outset: got %h expected %h", v, 32'h0);
    end
    bus_read(3'd5, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_mis++; $display("FAIL read_outclear: got %h expected %h", v, 32'h0);
    end
  endtask

  // PERIOD=2, PRESCALE=4: phase toggles 8 edges after the PERIOD write edge,
  // out_port follows one edge later; readdata shows STATUS one edge late.
  task automatic test_blink;
    bus_write(3'd0, 32'h0);
    bus_write(3'd1, 32'h0000_0003);
    bus_write(3'd2, 32'h0000_0002);
    address = 3'd3;
    tick(8);
    n_cmp++;
    if (out_port !== 8'h00) begin
      n_mis++; $display("FAIL blink_e8_out: got %h expected %h", out_port, 8'h00);
    end
    tick(1);
    n_cmp++;
    if (out_port !== 8'h03) begin
      n_mis++; $display("FAIL blink_e9_out: got %h expected %h", out_port, 8'h03);
    end
    n_cmp++;
    if (readdata !== 32'h1) begin
      n_mis++; $display("FAIL blink_e9_status: got %h expected %h", readdata, 32'h1);
    end
    tick(7);
    n_cmp++;
    if (out_port !== 8'h03) begin
      n_mis++; $display("FAIL blink_e16_out: got %h expected %h", out_port, 8'h03);
    end
    tick(1);
    n_cmp++;
    if (out_port !== 8'h00) begin
      n_mis++; $display("FAIL blink_e17_out: got %h expected %h", out_port, 8'h00);
    end
    n_cmp++;
    if (readdata !== 32'h0) begin
      n_mis++; $display("FAIL blink_e17_status: got %h expected %h", readdata, 32'h0);
    end
    tick(8);
    n_cmp++;
    if (out_port !== 8'h03) begin
      n_mis++; $display("FAIL blink_e25_out: got %h expected %h", out_port, 8'h03);
    end
  endtask

  task automatic test_freeze_restart;
    int bad;
    bus_write(3'd2, 32'h0);
    address = 3'd3;
    tick(1);
    n_cmp++;
    if (out_port !== 8'h00) begin
      n_mis++; $display("FAIL freeze_out: got %h expected %h", out_port, 8'h00);
    end
    n_cmp++;
    if (readdata !== 32'h0) begin
      n_mis++; $display("FAIL freeze_status: got %h expected %h", readdata, 32'h0);
    end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (out_port !== 8'h00 || readdata !== 32'h0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_mis++; $display("FAIL freeze_hold: got %0d toggled cycles expected %0d", bad, 0);
    end
    bus_write(3'd2, 32'h0000_0001);
    address = 3'd3;
    tick(4);
    n_cmp++;
    if (out_port !== 8'h00) begin
      n_mis++; $display("FAIL restart_w4_out: got %h expected %h", out_port, 8'h00);
    end
    n_cmp++;
    if (readdata !== 32'h0) begin
      n_mis++; $display("FAIL restart_w4_status: got %h expected %h", readdata, 32'h0);
    end
    tick(1);
    n_cmp++;
    if (out_port !== 8'h03) begin
      n_mis++; $display("FAIL restart_w5_out: got %h expected %h", out_port, 8'h03);
    end
    n_cmp++;
    if (readdata !== 32'h1) begin
      n_mis++; $display("FAIL restart_w5_status: got %h expected %h", readdata, 32'h1);
    end
  endtask

  task automatic test_ignored;
    logic [31:0] v;
    bus_write(3'd2, 32'h0);
    bus_write(3'd0, 32'h0000_005A);
    address    = 3'd0;
    writedata  = 32'h0000_00FF;
    chipselect = 1'b0;
    write_n    = 1'b0;
    tick(1);
    write_n    = 1'b1;
    bus_read(3'd0, v);
    n_cmp++;
    if (v !== 32'h0000_005A) begin
      n_mis++; $display("FAIL nocs_write: got %h expected %h", v, 32'h0000_005A);
    end
    bus_write(3'd3, 32'hFFFF_FFFF);
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_write(3'd7, 32'hFFFF_FFFF);
    bus_read(3'd0, v);
    n_cmp++;
    if (v !== 32'h0000_005A) begin
      n_mis++; $display("FAIL ignored_data: got %h expected %h", v, 32'h0000_005A);
    end
    bus_read(3'd1, v);
    n_cmp++;
    if (v !== 32'h0000_0003) begin
      n_mis++; $display("FAIL ignored_blink_en: got %h expected %h", v, 32'h0000_0003);
    end
    bus_read(3'd2, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_mis++; $display("FAIL ignored_period: got %h expected %h", v, 32'h0);
    end
    bus_read(3'd3, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_mis++; $display("FAIL ignored_status: got %h expected %h", v, 32'h0);
    end
    bus_read(3'd6, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_mis++; $display("FAIL read_addr6: got %h expected %h", v, 32'h0);
    end
    bus_write(3'd2, 32'hFFFF_0005);
    bus_read(3'd2, v);
    n_cmp++;
    if (v !== 32'h0000_0005) begin
      n_mis++; $display("FAIL period_mask: got %h expected %h", v, 32'h0000_0005);
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] v;
    int bad;
    bus_write(3'd0, 32'h0);
    bus_write(3'd2, 32'h0000_0001);
    address = 3'd3;
    tick(5);
    n_cmp++;
    if (out_port !== 8'h03) begin
      n_mis++; $display("FAIL prereset_out: got %h expected %h", out_port, 8'h03);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (out_port !== 8'h00) begin
      n_mis++; $display("FAIL async_reset_out: got %h expected %h", out_port, 8'h00);
    end
    n_cmp++;
    if (readdata !== 32'h0) begin
      n_mis++; $display("FAIL async_reset_status: got %h expected %h", readdata, 32'h0);
    end
    #1;
    reset = 1'b0;
    bus_read(3'd1, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_mis++; $display("FAIL postreset_blink_en: got %h expected %h", v, 32'h0);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (out_port !== 8'h00) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_mis++; $display("FAIL postreset_hold: got %0d toggled cycles expected %0d", bad, 0);
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_mis      = 0;
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    test_reset;
    test_data_write;
    test_set_clear;
    test_blink;
    test_freeze_restart;
    test_ignored;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
